exc_sequencer: RTL

- Exception-entry controller in front of the pipeline exception unit.
- Collects one synchronous source (invalid opcode from decode) and NSRC external interrupt lines, and prioritises them.
- Drives the Exc request and EStatus code into the exception unit, then holds the request until the unit acknowledges a vector fetch (ExcAck).
- Tracks handler occupancy until ERET. Blocks nested entry and flags faults.

---
 rtl/exc_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/exc_sequencer.sv
// Exception-entry sequencer: prioritises the invalid-opcode trap against external interrupt lines,
// holds Exc until the exception unit fetches the vector, then tracks handler occupancy until ERET.
module exc_sequencer #(
  parameter int NSRC    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            invalid_op_D,
  input  logic [NSRC-1:0] irq_req,
  input  logic [NSRC-1:0] irq_mask,
  input  logic            ERet,
  input  logic            ExcAck,
  output logic            Exc,
  output logic [3:0]      EStatus,
  output logic [NSRC-1:0] irq_clear,
  output logic            flush,
  output logic            in_handler,
  output logic            exc_err
);

  localparam int              CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    HANDLER = 2'd2
  } state_t;

  state_t           state;
  logic [NSRC-1:0]  irq_q;
  logic [NSRC-1:0]  pending;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       win_idx_q;
  logic             win_irq_q;

  logic [NSRC-1:0]  rise;
  logic [NSRC-1:0]  eligible;
  logic [NSRC-1:0]  win_oh;
  logic [2:0]       win_idx;

  function automatic logic [2:0] lowest_idx(input logic [NSRC-1:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  function automatic logic [NSRC-1:0] idx_onehot(input logic [2:0] idx);
    logic [NSRC-1:0] oh;
    for (int i = 0; i < NSRC; i++) begin
      oh[i] = (idx == 3'(i));
    end
    return oh;
  endfunction

  // An edge arriving this cycle is already a candidate, giving one cycle from request to Exc.
  assign rise     = irq_req & ~irq_q;
  assign eligible = (pending | rise) & irq_mask;
  assign win_idx  = lowest_idx(eligible);
  assign win_oh   = idx_onehot(win_idx_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      irq_q      <= '0;
      pending    <= '0;
      cnt        <= '0;
      win_idx_q  <= '0;
      win_irq_q  <= 1'b0;
      Exc        <= 1'b0;
      EStatus    <= 4'h0;
      irq_clear  <= '0;
      flush      <= 1'b0;
      in_handler <= 1'b0;
      exc_err    <= 1'b0;
    end else begin
      irq_q     <= irq_req;
      pending   <= pending | rise;
      irq_clear <= '0;
      flush     <= 1'b0;

      case (state)
        IDLE: begin
          if (invalid_op_D) begin
            EStatus   <= 4'h1;
            win_irq_q <= 1'b0;
            cnt       <= '0;
            Exc       <= 1'b1;
            state     <= REQ;
          end else if (|eligible) begin
            EStatus   <= 4'h8 + {1'b0, win_idx};
            win_idx_q <= win_idx;
            win_irq_q <= 1'b1;
            cnt       <= '0;
            Exc       <= 1'b1;
            state     <= REQ;
          end
        end

        REQ: begin
          // Acknowledge takes precedence over an abort landing on the same cycle.
          if (ExcAck) begin
            Exc        <= 1'b0;
            flush      <= 1'b1;
            in_handler <= 1'b1;
            state      <= HANDLER;
            if (win_irq_q) begin
              irq_clear <= win_oh;
              pending   <= (pending & ~win_oh) | rise;
            end
          end else if (cnt == CNT_LAST) begin
            Exc     <= 1'b0;
            exc_err <= 1'b1;
            state   <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        HANDLER: begin
          if (invalid_op_D) exc_err <= 1'b1;
          if (ERet) begin
            in_handler <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
